// File: rtl/video_mixer_pol.sv
// Core-side video mixer without scandoubler: colour expansion to 8 bits, sync
// polarity normalisation, scanline darkening, freeze blanking and CE/DE generation.
module video_mixer_pol #(
  parameter int IN_BITS    = 8,
  parameter int SCANLINES  = 1,
  parameter int POL_DETECT = 1
) (
  input  logic               CLK_VIDEO,
  input  logic               RESET_N,
  input  logic               ce_pix,
  input  logic               freeze,
  input  logic [1:0]         scanlines,
  input  logic [IN_BITS-1:0] R,
  input  logic [IN_BITS-1:0] G,
  input  logic [IN_BITS-1:0] B,
  input  logic               HSync,
  input  logic               VSync,
  input  logic               HBlank,
  input  logic               VBlank,
  output logic               CE_PIXEL,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic               hs_neg,
  output logic               vs_neg
);

  localparam int REP_W = 8 * IN_BITS;

  // Replicating the value eight times always yields at least 8 bits; the top
  // byte is the MSB-first repetition truncated to 8 bits.
  function automatic logic [7:0] expand(input logic [IN_BITS-1:0] v);
    logic [REP_W-1:0] rep;
    rep = {8{v}};
    return rep[REP_W-1 -: 8];
  endfunction

  function automatic logic [7:0] darken(input logic [7:0] x, input logic [1:0] m);
    case (m)
      2'd1:    return x - {2'b00, x[7:2]};
      2'd2:    return {1'b0, x[7:1]};
      2'd3:    return {2'b00, x[7:2]};
      default: return x;
    endcase
  endfunction

  logic       frz_s1, frz_s2;
  logic       hblank_d, vblank_d;
  logic       ce_pix_d, ce_osc, fs_osc;
  logic       line_odd;
  logic       hs_n, vs_n, hs_rise, vs_rise;
  logic [1:0] scan_mode;

  logic [7:0] r_p1, g_p1, b_p1;
  logic       hs_p1, vs_p1, hde_p1, vde_p1;
  logic [7:0] r_p2, g_p2, b_p2;
  logic       hs_p2, vs_p2, hde_p2, vde_p2;
  logic       old_hde;

  always_comb begin
    hs_n      = HSync ^ hs_neg;
    vs_n      = VSync ^ vs_neg;
    hs_rise   = hs_n & ~hs_p1;
    vs_rise   = vs_n & ~vs_p1;
    scan_mode = (SCANLINES != 0 && line_odd) ? scanlines : 2'd0;
  end

  // Freeze synchroniser and polarity detection. Sync is inactive when blank
  // ends, so the level sampled there is the idle level of that sync.
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      frz_s1   <= 1'b0;
      frz_s2   <= 1'b0;
      hblank_d <= 1'b0;
      vblank_d <= 1'b0;
      hs_neg   <= 1'b0;
      vs_neg   <= 1'b0;
    end else begin
      frz_s1   <= freeze;
      frz_s2   <= frz_s1;
      hblank_d <= HBlank;
      vblank_d <= VBlank;
      if (POL_DETECT != 0) begin
        if (hblank_d && !HBlank) hs_neg <= HSync;
        if (vblank_d && !VBlank) vs_neg <= VSync;
      end
    end
  end

  // Line parity and CE mode. A frame start latches whether ce_pix toggled
  // during the previous frame; a toggling ce_pix is turned into rising-edge pulses.
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      line_odd <= 1'b0;
      ce_pix_d <= 1'b0;
      ce_osc   <= 1'b0;
      fs_osc   <= 1'b0;
      CE_PIXEL <= 1'b0;
    end else begin
      ce_pix_d <= ce_pix;
      if (vs_rise) line_odd <= 1'b0;
      else if (hs_rise) line_odd <= ~line_odd;
      if (vs_rise) begin
        fs_osc <= ce_osc;
        ce_osc <= 1'b0;
      end else if (ce_pix != ce_pix_d) begin
        ce_osc <= 1'b1;
      end
      CE_PIXEL <= fs_osc ? (~ce_pix_d & ce_pix) : ce_pix;
    end
  end

  // Stage p1: expansion, freeze blanking, normalised sync and enables
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      hde_p1 <= 1'b0;
      vde_p1 <= 1'b0;
    end else begin
      r_p1   <= frz_s2 ? 8'd0 : expand(R);
      g_p1   <= frz_s2 ? 8'd0 : expand(G);
      b_p1   <= frz_s2 ? 8'd0 : expand(B);
      hs_p1  <= hs_n;
      vs_p1  <= vs_n;
      hde_p1 <= ~HBlank;
      vde_p1 <= ~VBlank;
    end
  end

  // Stage p2: scanline darkening
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      hde_p2 <= 1'b0;
      vde_p2 <= 1'b0;
    end else begin
      r_p2   <= darken(r_p1, scan_mode);
      g_p2   <= darken(g_p1, scan_mode);
      b_p2   <= darken(b_p1, scan_mode);
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      hde_p2 <= hde_p1;
      vde_p2 <= vde_p1;
    end
  end

  // Output stage: DE is only reloaded on an hde change so it steps at line edges
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      VGA_R   <= '0;
      VGA_G   <= '0;
      VGA_B   <= '0;
      VGA_HS  <= 1'b0;
      VGA_VS  <= 1'b0;
      VGA_DE  <= 1'b0;
      old_hde <= 1'b0;
    end else if (CE_PIXEL) begin
      VGA_R   <= r_p2;
      VGA_G   <= g_p2;
      VGA_B   <= b_p2;
      VGA_HS  <= hs_p2;
      VGA_VS  <= vs_p2;
      old_hde <= hde_p2;
      if (hde_p2 != old_hde) VGA_DE <= vde_p2 & hde_p2;
    end
  end

endmodule
